// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port and packed output stream bundle (optional out_par under PACK_PARITY_EN)
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
);
    localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;

    logic [DSIZE-1:0]      rdata;
    logic                  rempty;
    logic                  rinc;
    logic                  flush;
    logic [DSIZE*PACK-1:0] out_data;
    logic [PACK-1:0]       out_keep;
    logic                  out_valid;
    logic                  out_ready;
    logic [CW-1:0]         lanes;
`ifdef PACK_PARITY_EN
    logic [PACK-1:0]       out_par;
`endif

    // Packer side: consumes the FIFO, produces the packed stream.
    modport slave (
`ifdef PACK_PARITY_EN
        output out_par,
`endif
        input  rdata, rempty, flush, out_ready,
        output rinc, out_data, out_keep, out_valid, lanes
    );

    // Environment side: FIFO read port plus stream sink.
    modport master (
`ifdef PACK_PARITY_EN
        input  out_par,
`endif
        output rdata, rempty, flush, out_ready,
        input  rinc, out_data, out_keep, out_valid, lanes
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs PACK FIFO words into one keep-masked output word (lane parity under PACK_PARITY_EN)
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) (
    input logic             rclk,
    input logic             rrst_n,
    fifo_rd_packer_if.slave bus
);
    localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [DSIZE-1:0]      asm_q [PACK];
    logic [DSIZE-1:0]      asm_n [PACK];
    logic [CW-1:0]         cnt_q, cnt_n;
    logic                  fp_q, fp_n;
    logic [DSIZE*PACK-1:0] od_q, od_n, full_word, part_word;
    logic [PACK-1:0]       ok_q, ok_n, part_keep;
    logic                  ov_q, ov_n;
    logic                  out_free, pop;
`ifdef PACK_PARITY_EN
    logic [PACK-1:0]       par_q, par_n;
`endif

    assign out_free = !ov_q || bus.out_ready;
    // The last lane may only be popped when the output register can take the word.
    assign pop      = rrst_n && !bus.rempty && !fp_q && ((cnt_q != LAST) || out_free);

    assign bus.rinc      = pop;
    assign bus.out_data  = od_q;
    assign bus.out_keep  = ok_q;
    assign bus.out_valid = ov_q;
    assign bus.lanes     = cnt_q;
`ifdef PACK_PARITY_EN
    assign bus.out_par   = par_q;
`endif

    // Candidate words: a full word closes with the live rdata, a partial word zeroes unfilled lanes.
    always_comb begin
        full_word = '0;
        part_word = '0;
        part_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            full_word[i*DSIZE +: DSIZE] = (i == PACK - 1) ? bus.rdata : asm_q[i];
            part_keep[i]                = CW'(i) < cnt_q;
            part_word[i*DSIZE +: DSIZE] = part_keep[i] ? asm_q[i] : '0;
        end
    end

    // Next-state: pops fill lanes, completion or a pending flush loads the output register.
    always_comb begin
        asm_n = asm_q;
        cnt_n = cnt_q;
        fp_n  = fp_q || bus.flush;
        od_n  = od_q;
        ok_n  = ok_q;
        ov_n  = ov_q && !bus.out_ready;
        if (pop) begin
            if (cnt_q == LAST) begin
                od_n  = full_word;
                ok_n  = '1;
                ov_n  = 1'b1;
                cnt_n = '0;
            end else begin
                asm_n[cnt_q] = bus.rdata;
                cnt_n        = cnt_q + 1'b1;
            end
        end else if (fp_q) begin
            if (cnt_q == '0) begin
                fp_n = bus.flush;
            end else if (out_free) begin
                od_n  = part_word;
                ok_n  = part_keep;
                ov_n  = 1'b1;
                cnt_n = '0;
                fp_n  = bus.flush;
            end
        end
`ifdef PACK_PARITY_EN
        for (int i = 0; i < PACK; i++) begin
            par_n[i] = ok_n[i] && (^od_n[i*DSIZE +: DSIZE]);
        end
`endif
    end

    // State registers; reset discards any partial word and the pending output.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < PACK; i++) begin
                asm_q[i] <= '0;
            end
            cnt_q <= '0;
            fp_q  <= 1'b0;
            od_q  <= '0;
            ok_q  <= '0;
            ov_q  <= 1'b0;
`ifdef PACK_PARITY_EN
            par_q <= '0;
`endif
        end else begin
            asm_q <= asm_n;
            cnt_q <= cnt_n;
            fp_q  <= fp_n;
            od_q  <= od_n;
            ok_q  <= ok_n;
            ov_q  <= ov_n;
`ifdef PACK_PARITY_EN
            par_q <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;
    logic rclk;
    logic rrst_n;

    fifo_rd_packer_if #(.DSIZE(8), .PACK(4)) bus ();

    fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus.slave)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic [7:0] fifo_q [$];
    int tests      = 0;
    int fails      = 0;
    int rinc_cnt   = 0;
    int ov_cycles  = 0;
    int empty_viol = 0;
    logic [31:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.rempty = (fifo_q.size() == 0);
        bus.rdata  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic cycle();
        logic pop_now;
        #3;
        if (bus.rinc && bus.rempty) empty_viol++;
        if (bus.out_valid) ov_cycles++;
        pop_now = bus.rinc;
        @(posedge rclk);
        if (pop_now && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            rinc_cnt++;
        end
        #1;
        drive_fifo();
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        rrst_n        = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        fifo_q.push_back(8'h55);
        drive_fifo();
        @(posedge rclk);
        #2;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_keep",  64'(bus.out_keep),  64'd0);
        check("reset_out_data",  64'(bus.out_data),  64'd0);
        check("reset_lanes",     64'(bus.lanes),     64'd0);
        check("reset_rinc",      64'(bus.rinc),      64'd0);
        cycles(2);
        check("reset_no_pop", 64'(fifo_q.size()), 64'd1);
        fifo_q.delete();
        drive_fifo();
        rrst_n = 1'b1;
        cycle();

        // Basic packing
        rinc_cnt = 0; ov_cycles = 0;
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_fifo();
        #1;
        cycles(4);
        check("basic_valid", 64'(bus.out_valid), 64'd1);
        check("basic_data",  64'(bus.out_data),  64'h44332211);
        check("basic_keep",  64'(bus.out_keep),  64'hf);
        cycles(3);
        check("basic_rinc_count", 64'(rinc_cnt),  64'd4);
        check("basic_valid_once", 64'(ov_cycles), 64'd1);
        check("basic_valid_drop", 64'(bus.out_valid), 64'd0);

        // Back-pressure
        rinc_cnt = 0;
        bus.out_ready = 1'b0;
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        drive_fifo();
        #1;
        cycles(10);
        check("bp_data",  64'(bus.out_data), 64'h04030201);
        check("bp_keep",  64'(bus.out_keep), 64'hf);
        check("bp_lanes", 64'(bus.lanes),    64'd3);
        check("bp_rinc",  64'(bus.rinc),     64'd0);
        check("bp_fifo_left", 64'(fifo_q.size()), 64'd1);
        held = bus.out_data;
        cycles(3);
        check("bp_stable", 64'(held), 64'h04030201);
        check("bp_stable_now", 64'(bus.out_data), 64'h04030201);
        bus.out_ready = 1'b1;
        #1;
        cycle();
        check("bp_next_data",  64'(bus.out_data),  64'h08070605);
        check("bp_next_valid", 64'(bus.out_valid), 64'd1);
        check("bp_next_lanes", 64'(bus.lanes),     64'd0);
        cycle();
        check("bp_drain", 64'(bus.out_valid), 64'd0);
        check("bp_rinc_count", 64'(rinc_cnt), 64'd8);

        // Partial flush
        fifo_q = '{8'hAA, 8'hBB};
        drive_fifo();
        #1;
        cycles(2);
        check("pf_lanes_before", 64'(bus.lanes), 64'd2);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        check("pf_not_yet", 64'(bus.out_valid), 64'd0);
        cycle();
        check("pf_valid", 64'(bus.out_valid), 64'd1);
        check("pf_data",  64'(bus.out_data),  64'h0000BBAA);
        check("pf_keep",  64'(bus.out_keep),  64'h3);
        check("pf_lanes", 64'(bus.lanes),     64'd0);
        cycle();

        // Empty flush
        rinc_cnt = 0; ov_cycles = 0;
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        cycles(3);
        check("ef_no_word", 64'(ov_cycles), 64'd0);
        check("ef_no_rinc", 64'(rinc_cnt),  64'd0);

        // Mid-word reset
        fifo_q = '{8'hA0, 8'hA1, 8'hA2};
        drive_fifo();
        #1;
        cycles(3);
        check("mr_lanes_before", 64'(bus.lanes), 64'd3);
        rrst_n = 1'b0;
        #1;
        check("mr_lanes_reset", 64'(bus.lanes),     64'd0);
        check("mr_valid_reset", 64'(bus.out_valid), 64'd0);
        fifo_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        drive_fifo();
        #1;
        check("mr_rinc_in_reset", 64'(bus.rinc), 64'd0);
        cycles(2);
        check("mr_no_pop", 64'(fifo_q.size()), 64'd4);
        rrst_n = 1'b1;
        #1;
        cycles(4);
        check("mr_data",  64'(bus.out_data), 64'h13121110);
        check("mr_keep",  64'(bus.out_keep), 64'hf);
        cycle();

`ifdef PACK_PARITY_EN
        fifo_q = '{8'h01, 8'h03, 8'h07, 8'h00};
        drive_fifo();
        #1;
        cycles(4);
        check("par_data", 64'(bus.out_data), 64'h00070301);
        check("par_bits", 64'(bus.out_par),  64'h5);
        cycle();
`endif

        check("never_rinc_when_empty", 64'(empty_viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the asynchronous FIFO. It pops DSIZE-bit words from the FIFO read port in the rclk domain and packs PACK consecutive words into one wide output word. The wide word is presented on a valid/ready stream with a per-lane keep mask. A flush request emits a partially filled word, so trailing data is never stranded.

## Interface
- DSIZE, 8: FIFO data width (bits per lane).
- PACK, 4: lanes per output word; must be ≥ 2; lane counter width is clog2(PACK).
- rclk  in  1  read-domain clock; every register in the block is clocked on the posedge.
- rrst_n  in  1  reset, asynchronous assert, active-low; release is synchronous to rclk upstream.
- rdata  in  DSIZE  FIFO read data; valid combinationally whenever rempty=0 (first-word fall-through).
- rempty  in  1  FIFO empty flag.
- rinc  out  1  pop strobe to the FIFO; combinational.
- flush  in  1  single-cycle request to emit the partial word.
- out_data  out  DSIZE*PACK  packed word; lane 0 is bits [DSIZE-1:0].
- out_keep  out  PACK  bit i=1 means lane i is valid.
- out_valid  out  1  output holds a word.
- out_ready  in  1  downstream accepts the word.
- lanes  out  clog2(PACK)  current fill count of the assembly register.

## Operation
- Assembly register asm[PACK] and counter asm_cnt (0..PACK-1).
- Output register holds out_data/out_keep/out_valid.
- A transfer happens when out_valid && out_ready at a posedge.
- out_free = !out_valid || out_ready.
- pop = rinc = rrst_n && !rempty && !flush_pend && (asm_cnt != PACK-1 || out_free).
- On a pop, rdata is written to lane asm_cnt.
  - If asm_cnt < PACK-1: asm_cnt increments.
  - If asm_cnt == PACK-1: asm plus rdata load the output register directly, out_keep = all ones, out_valid=1, asm_cnt returns to 0.
- flush sets flush_pend. While flush_pend=1, no pops occur.
  - asm_cnt > 0 and out_free: the output loads asm with unused lanes zeroed, out_keep = (1<<asm_cnt)-1, asm_cnt=0, flush_pend clears.
  - asm_cnt == 0: flush_pend clears on the next edge and no word is emitted.
- flush in the same cycle as a pop: the popped word is included in the flushed word.
- When out_valid=1 and out_ready=0, out_data and out_keep hold stable. Assembly continues up to PACK-1 lanes, then rinc deasserts.
- If a completed or flushed word loads in the same cycle as a transfer, out_valid stays 1.
- Reset values: out_data=0, out_keep=0, out_valid=0, lanes=0, flush_pend=0, assembly cleared. rinc=0 while rrst_n=0.
- Reset mid-word: partially assembled data and the output word are discarded, and no further pop occurs until release.

## Timing
- A pop is registered at the rclk edge where rinc=1.
- out_valid rises at the edge that pops lane PACK-1, so the first word appears PACK cycles after the first pop with a non-empty FIFO.
- Sustained throughput with out_ready=1 and a non-empty FIFO: one pop per cycle, one word per PACK cycles, no bubbles.
- Flush latency: a partial word is visible 2 edges after the flush pulse when out_free; otherwise it waits until out_free.
- rinc depends combinationally on rempty and out_ready. No other combinational input-to-output paths exist.

## Configuration
- PACK_PARITY_EN defined:
  - Adds output out_par [PACK-1:0], bit i = even parity (XOR) of lane i.
  - It is registered with out_data, is 0 for unkept lanes, and resets to 0.
- PACK_PARITY_EN undefined: the out_par port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic packing:
  - Stimulus: FIFO holds 0x11,0x22,0x33,0x44; out_ready=1.
  - Response: exactly 4 rinc cycles; out_data=0x44332211, out_keep=4'b1111; out_valid for one cycle.
- Back-pressure:
  - Stimulus: out_ready=0; FIFO holds 8 words 0x01..0x08.
  - Response: out_data=0x04030201 held stable; lanes=3 with rinc=0 while 0x08 remains in the FIFO.
  - Then out_ready=1: the next word is 0x08070605.
- Partial flush:
  - Stimulus: pop 0xAA,0xBB, then pulse flush.
  - Response: out_data=0x0000BBAA, out_keep=4'b0011; lanes returns to 0.
- Empty-FIFO flush: flush with lanes=0 → out_valid stays 0 and no rinc occurs.
- Mid-word reset and empty guard:
  - Stimulus: pop 3 words, assert rrst_n=0, release, then feed 0x10..0x13.
  - Response: out_data=0x13121110 with no stale lanes; rinc is never 1 while rempty=1.
- Parity (PACK_PARITY_EN defined): lanes 0x01,0x03,0x07,0x00 → out_par=4'b0101.
